// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter in front of the single command port of apb_bridge.
// Up to NUM_REQ requesters (CPU port, DMA engines) raise a request level with
// their transfer fields; one transfer at a time is granted, strobed into the
// bridge, and completed with a one-cycle one-hot acknowledge carrying the read
// data and error status. A watchdog aborts transfers whose ready never comes.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   ADDR_WIDTH  bridge address width
//   DATA_WIDTH  bridge data width
//   TIMEOUT     WAIT_RDY cycles allowed before abort (>= 2)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   per-requester request level
//   req_wr     in   per-requester write (1) / read (0)
//   req_dsel   in   per-requester size: 00 word, 01 half, 10 byte, 11 illegal
//   req_addr   in   per-requester address, packed NUM_REQ x ADDR_WIDTH
//   req_wdata  in   per-requester write data, packed NUM_REQ x DATA_WIDTH
//   ack        out  one-hot, one-cycle completion pulse
//   rsp_rdata  out  read data, valid with ack and then held
//   rsp_err    out  error flag, valid with ack and then held
//   grant_id   out  index of the current or last winner
//   busy       out  high whenever the arbiter is not idle
//   m_trnsfr   out  one-cycle bridge transfer strobe
//   m_wr       out  bridge direction
//   m_dsel     out  bridge size select
//   m_addr     out  bridge address
//   m_wdata    out  bridge write data
//   m_ready    in   bridge completion (high one or more cycles)
//   m_rdata    in   bridge read data, valid with m_ready
//   m_slverr   in   bridge slave error, valid with m_ready
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [2*NUM_REQ-1:0]           req_dsel,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]  req_addr,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [IDW-1:0]                 grant_id,
  output logic                           busy,
  output logic                           m_trnsfr,
  output logic                           m_wr,
  output logic [1:0]                     m_dsel,
  output logic [ADDR_WIDTH-1:0]          m_addr,
  output logic [DATA_WIDTH-1:0]          m_wdata,
  input  logic                           m_ready,
  input  logic [DATA_WIDTH-1:0]          m_rdata,
  input  logic                           m_slverr
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_RELEASE  = 3'd3,
    S_RESP_ERR = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Round-robin pick: returns {found, index}. Candidates are scanned from the
  // farthest (ptr + NUM_REQ - 1) to the nearest (ptr), so the requester closest
  // to the pointer overwrites all others and wins.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [IDW-1:0]     p);
    logic           found;
    logic [IDW-1:0] idx;
    int             c;
    found = 1'b0;
    idx   = {IDW{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = (int'(p) + k) % NUM_REQ;
      if (r[IDW'(c)]) begin
        found = 1'b1;
        idx   = IDW'(c);
      end else begin
        found = found;
        idx   = idx;
      end
    end
    return {found, idx};
  endfunction

  // Pointer value after serving requester g (wraps modulo NUM_REQ).
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
    logic [IDW-1:0] n;
    if (g == IDW'(NUM_REQ - 1)) begin
      n = {IDW{1'b0}};
    end else begin
      n = g + IDW'(1);
    end
    return n;
  endfunction

  // One-hot acknowledge vector for requester g.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] g);
    logic [NUM_REQ-1:0] v;
    v    = {NUM_REQ{1'b0}};
    v[g] = 1'b1;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                 state_r;
  logic [IDW-1:0]         ptr_r;
  logic [TW-1:0]          timer_r;
  logic [NUM_REQ-1:0]     ack_r;
  logic [DATA_WIDTH-1:0]  rsp_rdata_r;
  logic                   rsp_err_r;
  logic [IDW-1:0]         grant_id_r;
  logic                   busy_r;
  logic                   m_trnsfr_r;
  logic                   m_wr_r;
  logic [1:0]             m_dsel_r;
  logic [ADDR_WIDTH-1:0]  m_addr_r;
  logic [DATA_WIDTH-1:0]  m_wdata_r;

  // ---------------------------------------------------------------------------
  // Request field unpacking and winner selection
  // ---------------------------------------------------------------------------
  logic [1:0]             dsel_a_s  [NUM_REQ];
  logic [ADDR_WIDTH-1:0]  addr_a_s  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_a_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dsel_a_s[g]  = req_dsel[2*g +: 2];
    assign addr_a_s[g]  = req_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
    assign wdata_a_s[g] = req_wdata[DATA_WIDTH*g +: DATA_WIDTH];
  end

  logic [IDW:0]   pick_s;
  logic           win_found_s;
  logic [IDW-1:0] win_idx_s;

  // Combinational round-robin search over the live request levels.
  always_comb begin
    pick_s      = rr_pick(req, ptr_r);
    win_found_s = pick_s[IDW];
    win_idx_s   = pick_s[IDW-1:0];
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------

  // Transfer sequencing, bridge command registers and requester response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ptr_r       <= {IDW{1'b0}};
      timer_r     <= {TW{1'b0}};
      ack_r       <= {NUM_REQ{1'b0}};
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
      grant_id_r  <= {IDW{1'b0}};
      busy_r      <= 1'b0;
      m_trnsfr_r  <= 1'b0;
      m_wr_r      <= 1'b0;
      m_dsel_r    <= 2'b00;
      m_addr_r    <= {ADDR_WIDTH{1'b0}};
      m_wdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      ack_r      <= {NUM_REQ{1'b0}};
      m_trnsfr_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (win_found_s) begin
            // Latch the winner's fields now; they stay put until the next
            // grant so the bridge sees a stable command for the whole access.
            grant_id_r <= win_idx_s;
            m_wr_r     <= req_wr[win_idx_s];
            m_dsel_r   <= dsel_a_s[win_idx_s];
            m_addr_r   <= addr_a_s[win_idx_s];
            m_wdata_r  <= wdata_a_s[win_idx_s];
            busy_r     <= 1'b1;
            if (dsel_a_s[win_idx_s] == 2'b11) begin
              state_r <= S_RESP_ERR;
            end else begin
              // Strobe is registered here so it is high exactly while in ISSUE.
              m_trnsfr_r <= 1'b1;
              state_r    <= S_ISSUE;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end

        S_ISSUE: begin
          timer_r <= {TW{1'b0}};
          state_r <= S_WAIT_RDY;
        end

        S_WAIT_RDY: begin
          if (m_ready) begin
            // Ready takes priority over a watchdog expiry in the same cycle.
            if (!m_wr_r) begin
              rsp_rdata_r <= m_rdata;
            end else begin
              rsp_rdata_r <= rsp_rdata_r;
            end
            rsp_err_r <= m_slverr;
            ack_r     <= onehot(grant_id_r);
            ptr_r     <= next_ptr(grant_id_r);
            state_r   <= S_RELEASE;
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            // Watchdog abort: read data is left as it was.
            rsp_err_r <= 1'b1;
            ack_r     <= onehot(grant_id_r);
            ptr_r     <= next_ptr(grant_id_r);
            busy_r    <= 1'b0;
            state_r   <= S_IDLE;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end

        S_RELEASE: begin
          // Hold off the next strobe until the bridge drops ready.
          if (!m_ready) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            state_r <= S_RELEASE;
          end
        end

        S_RESP_ERR: begin
          // Illegal size: answer with an error, never touch the bridge.
          rsp_err_r <= 1'b1;
          ack_r     <= onehot(grant_id_r);
          ptr_r     <= next_ptr(grant_id_r);
          busy_r    <= 1'b0;
          state_r   <= S_IDLE;
        end

        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output ports
  // ---------------------------------------------------------------------------
  assign ack       = ack_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign grant_id  = grant_id_r;
  assign busy      = busy_r;
  assign m_trnsfr  = m_trnsfr_r;
  assign m_wr      = m_wr_r;
  assign m_dsel    = m_dsel_r;
  assign m_addr    = m_addr_r;
  assign m_wdata   = m_wdata_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Directed bench for apb_req_arbiter. Stimulus pushes the hand-computed
// expected acknowledge (winner, error, read data, latency) into a scoreboard
// queue; a monitor pops and compares every time the DUT pulses ack. A small
// bridge model answers each strobe with a one-cycle ready (or never, when
// br_hang is set).
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      req;
  logic [NR-1:0]      req_wr;
  logic [2*NR-1:0]    req_dsel;
  logic [AW*NR-1:0]   req_addr;
  logic [DW*NR-1:0]   req_wdata;
  logic [NR-1:0]      ack;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [1:0]         grant_id;
  logic               busy;
  logic               m_trnsfr;
  logic               m_wr;
  logic [1:0]         m_dsel;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic               m_ready;
  logic [DW-1:0]      m_rdata;
  logic               m_slverr;

  apb_req_arbiter #(
    .NUM_REQ   (NR),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_wr   (req_wr),
    .req_dsel (req_dsel),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .grant_id (grant_id),
    .busy     (busy),
    .m_trnsfr (m_trnsfr),
    .m_wr     (m_wr),
    .m_dsel   (m_dsel),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .m_slverr (m_slverr)
  );

  typedef struct {
    logic [NR-1:0] ack;
    logic [1:0]    gid;
    logic          err;
    logic          chk_rd;
    logic [DW-1:0] rd;
    int            e0;
    int            lat;
  } exp_t;

  exp_t          sb_q[$];
  int            n_chk   = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            trn_cnt = 0;
  logic          prev_trn = 1'b0;
  logic          br_hang  = 1'b0;
  logic [DW-1:0] br_rdata = 32'h0;
  logic          br_err   = 1'b0;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter, read only on falling edges
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the expected response of requester i; e0 is the edge that samples req.
  task automatic push(input int i, input logic err, input logic chk_rd,
                      input logic [DW-1:0] rd, input int lat);
    exp_t e;
    e.ack    = 4'b0001 << i;
    e.gid    = 2'(i);
    e.err    = err;
    e.chk_rd = chk_rd;
    e.rd     = rd;
    e.e0     = cyc + 1;
    e.lat    = lat;
    sb_q.push_back(e);
  endtask

  task automatic drive(input int i, input logic wr, input logic [1:0] dsel,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[i]             = wr;
    req_dsel[2*i +: 2]    = dsel;
    req_addr[AW*i +: AW]  = a;
    req_wdata[DW*i +: DW] = d;
    req[i]                = 1'b1;
  endtask

  // Wait (bounded) for requester i's ack, then drop its request.
  task automatic wait_ack(input int i);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (ack[i]) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ack_wait: requester %0d saw no ack, required one within 60 cycles", i);
    end
    req[i] = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // Bridge model: ready for one cycle, sampled two edges after the strobe edge.
  initial begin
    m_ready  = 1'b0;
    m_rdata  = 32'h0;
    m_slverr = 1'b0;
    forever begin
      @(negedge clk);
      if (m_trnsfr && !br_hang && !rst) begin
        @(negedge clk);
        m_ready  = 1'b1;
        m_rdata  = br_rdata;
        m_slverr = br_err;
        @(negedge clk);
        m_ready  = 1'b0;
        m_rdata  = 32'h0;
        m_slverr = 1'b0;
      end
    end
  end

  // Monitor: strobe shape and scoreboard comparison on every ack.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_trnsfr) begin
          trn_cnt++;
          chk("trnsfr_single_cycle", prev_trn, 1'b0);
        end
        prev_trn = m_trnsfr;
        if (ack != 4'b0000) begin
          chk("ack_onehot", $countones(ack), 1);
          if (sb_q.size() == 0) begin
            chk("unexpected_ack", ack, 4'b0000);
          end else begin
            e = sb_q.pop_front();
            chk("ack", ack, e.ack);
            chk("grant_id", grant_id, e.gid);
            chk("rsp_err", rsp_err, e.err);
            if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.rd);
            if (e.lat >= 0) chk("ack_latency", cyc - e.e0, e.lat);
          end
        end
      end else begin
        prev_trn = 1'b0;
      end
    end
  end

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
    $fatal(1, "simulation time limit");
  end

  // Directed stimulus
  initial begin
    int got;
    int t0;
    rst       = 1'b0;
    req       = 4'b0000;
    req_wr    = 4'b0000;
    req_dsel  = 8'h00;
    req_addr  = {(AW*NR){1'b0}};
    req_wdata = {(DW*NR){1'b0}};

    // Reset state
    #2 rst = 1'b1;
    #1 chk("reset_outputs", {ack, rsp_rdata, rsp_err, grant_id, busy, m_trnsfr,
                             m_wr, m_dsel, m_addr, m_wdata}, 128'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, ack, m_trnsfr}, 6'h0);

    // All four requesting continuously: grants 0,1,2,3,0 (writes keep rdata 0)
    br_rdata = 32'h12345678;
    br_err   = 1'b0;
    for (int i = 0; i < NR; i++) drive(i, 1'b1, 2'b00, 32'h100 + 32'(4*i), 32'hA0 + 32'(i));
    push(0, 1'b0, 1'b1, 32'h0, 2);
    push(1, 1'b0, 1'b1, 32'h0, -1);
    push(2, 1'b0, 1'b1, 32'h0, -1);
    push(3, 1'b0, 1'b1, 32'h0, -1);
    push(0, 1'b0, 1'b1, 32'h0, -1);
    got = 0;
    for (int n = 0; n < 200 && got < 5; n++) begin
      @(negedge clk);
      if (ack != 4'b0000) got++;
    end
    req = 4'b0000;
    chk("all_four_ack_count", got, 5);
    settle();

    // Requester 0 writes 0x0A3210 to 0xF0, ready at E2
    drive(0, 1'b1, 2'b00, 32'hF0, 32'h000A3210);
    push(0, 1'b0, 1'b1, 32'h0, 2);
    @(negedge clk);
    chk("strobe_e0", {m_trnsfr, m_wr, m_dsel, busy}, 5'b11001);
    chk("m_addr", m_addr, 32'hF0);
    chk("m_wdata", m_wdata, 32'h000A3210);
    @(negedge clk);
    chk("strobe_e1_low", m_trnsfr, 1'b0);
    wait_ack(0);
    settle();

    // Requester 2 reads halfword, bridge returns data with slave error
    br_rdata = 32'h510FCB29;
    br_err   = 1'b1;
    drive(2, 1'b0, 2'b01, 32'h200, 32'h0);
    push(2, 1'b1, 1'b1, 32'h510FCB29, 2);
    wait_ack(2);
    repeat (2) @(negedge clk);
    chk("rsp_held", {rsp_err, rsp_rdata}, {1'b1, 32'h510FCB29});
    settle();

    // Pointer is now 3: requester 3 beats requester 0, then 0 is served
    br_rdata = 32'h12345678;
    br_err   = 1'b0;
    drive(0, 1'b1, 2'b00, 32'h300, 32'h5);
    drive(3, 1'b1, 2'b00, 32'h30C, 32'h6);
    push(3, 1'b0, 1'b1, 32'h510FCB29, 2);
    push(0, 1'b0, 1'b1, 32'h510FCB29, -1);
    wait_ack(3);
    wait_ack(0);
    settle();

    // Bridge never answers: abort with error TIMEOUT edges after ISSUE
    br_hang = 1'b1;
    drive(1, 1'b0, 2'b00, 32'h400, 32'h0);
    push(1, 1'b1, 1'b1, 32'h510FCB29, TO + 1);
    wait_ack(1);
    br_hang = 1'b0;
    settle();

    // Next requester served normally after the abort
    drive(2, 1'b1, 2'b00, 32'h404, 32'h7);
    push(2, 1'b0, 1'b1, 32'h510FCB29, 2);
    wait_ack(2);
    settle();

    // Illegal size: error ack two edges after request, no strobe
    t0 = trn_cnt;
    drive(3, 1'b1, 2'b11, 32'h408, 32'h8);
    push(3, 1'b1, 1'b1, 32'h510FCB29, 1);
    wait_ack(3);
    settle();
    chk("illegal_dsel_no_strobe", trn_cnt - t0, 0);

    // Move the pointer to 2, then hang requester 3 in WAIT_RDY and reset
    drive(1, 1'b1, 2'b00, 32'h500, 32'h9);
    push(1, 1'b0, 1'b1, 32'h510FCB29, 2);
    wait_ack(1);
    settle();
    br_hang = 1'b1;
    drive(3, 1'b0, 2'b00, 32'h504, 32'h0);
    repeat (4) @(negedge clk);
    chk("busy_before_reset", {busy, m_addr}, {1'b1, 32'h504});
    #3 rst = 1'b1;
    #1 chk("reset_mid_transfer", {ack, rsp_rdata, rsp_err, grant_id, busy, m_trnsfr,
                                  m_wr, m_dsel, m_addr, m_wdata}, 128'h0);
    @(negedge clk);
    rst      = 1'b0;
    br_hang  = 1'b0;
    br_rdata = 32'hCAFE0003;
    drive(0, 1'b1, 2'b00, 32'h600, 32'hA);
    push(0, 1'b0, 1'b1, 32'h0, 2);
    push(3, 1'b0, 1'b1, 32'hCAFE0003, -1);
    wait_ack(0);
    wait_ack(3);
    settle();

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
